// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the IF stage and the ID-stage decoder:
// next-PC class encodings, reset/exception vectors, NOP word, the IF/ID
// payload layout and the branch-offset helper.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NPC_SEL_W = 2;
  localparam int unsigned IMM16_W   = 16;
  localparam int unsigned IMM26_W   = 26;

  // Next-PC class of the instruction sitting in ID
  typedef enum logic [NPC_SEL_W-1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JIMM   = 2'd2,
    NPC_JREG   = 2'd3
  } npc_sel_e;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam logic [XLEN-1:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;
  localparam logic [XLEN-1:0] NOP_WORD           = 32'h0000_0000;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
    logic            bd;
    logic            exc_adel;
  } if_id_t;

  // Sign-extended word offset of a conditional branch
  function automatic logic [XLEN-1:0] branch_offset(input logic [IMM16_W-1:0] imm16);
    return {{(XLEN-IMM16_W-2){imm16[IMM16_W-1]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_npc_calc.sv
// npc_calc: combinational next-PC candidate for the IF stage.
// Ports:
//   i_pc        current PC register
//   i_npc_sel   next-PC class of the ID instruction
//   i_cmp       comparator result for the ID instruction
//   i_id_pc     PC of the ID instruction
//   i_imm16     branch offset field
//   i_imm26     jump index field
//   i_rs_data   forwarded rs value (register jump target)
//   o_npc_c     next-PC candidate (combinational)
module npc_calc
  import if_fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0]    i_pc,
  input  npc_sel_e           i_npc_sel,
  input  logic               i_cmp,
  input  logic [XLEN-1:0]    i_id_pc,
  input  logic [IMM16_W-1:0] i_imm16,
  input  logic [IMM26_W-1:0] i_imm26,
  input  logic [XLEN-1:0]    i_rs_data,
  output logic [XLEN-1:0]    o_npc_c
);

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_id_pc_plus4;
  logic [XLEN-1:0] w_branch_target;
  logic [XLEN-1:0] w_jump_target;

  // Targets are relative to the delay-slot address (ID PC + 4); all wrap mod 2^32
  assign w_pc_plus4      = i_pc + XLEN'(4);
  assign w_id_pc_plus4   = i_id_pc + XLEN'(4);
  assign w_branch_target = w_id_pc_plus4 + branch_offset(i_imm16);
  assign w_jump_target   = {w_id_pc_plus4[XLEN-1:XLEN-4], i_imm26, 2'b00};

  // Next-PC mux; register jumps pass misaligned targets through untouched
  always_comb begin
    o_npc_c = w_pc_plus4;
    case (i_npc_sel)
      NPC_SEQ:    o_npc_c = w_pc_plus4;
      NPC_BRANCH: o_npc_c = i_cmp ? w_branch_target : w_pc_plus4;
      NPC_JIMM:   o_npc_c = w_jump_target;
      NPC_JREG:   o_npc_c = i_rs_data;
      default:    o_npc_c = w_pc_plus4;
    endcase
  end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage of the 5-stage MIPS pipeline. Owns the PC,
// selects the next PC from ID-stage branch/jump information (single
// architectural delay slot, no flush) and drives the IF/ID register.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   imem_addr / imem_rdata  instruction memory (combinational read)
//   stall                   freezes PC and IF/ID
//   redirect_valid/_pc      CP0 exception/ERET redirect, overrides stall
//   id_*                    ID-stage instruction info for next-PC selection
//   if_id_*                 registered IF/ID outputs
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [XLEN-1:0]      imem_addr,
  input  logic [XLEN-1:0]      imem_rdata,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  input  logic [NPC_SEL_W-1:0] id_npc_sel,
  input  logic                 id_cmp,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [IMM16_W-1:0]   id_imm16,
  input  logic [IMM26_W-1:0]   id_imm26,
  input  logic [XLEN-1:0]      id_rs_data,
  output logic [XLEN-1:0]      if_id_instr,
  output logic [XLEN-1:0]      if_id_pc,
  output logic                 if_id_valid,
  output logic                 if_id_bd,
  output logic                 if_id_exc_adel
);

  logic [XLEN-1:0] r_pc;
  if_id_t          r_if_id;
  logic [XLEN-1:0] w_npc;
  npc_sel_e        w_npc_sel;
  logic            w_fetch_misaligned;
  logic            w_id_is_cti;

  // The redirect target always comes from CP0; the vector is kept for reference only
  if (EXC_VECTOR[1:0] != 2'b00) begin : g_exc_vector_misaligned
  end

  assign w_npc_sel          = npc_sel_e'(id_npc_sel);
  assign w_fetch_misaligned = (r_pc[1:0] != 2'b00);
  // A bubble in ID is never a branch, so it can never mark a delay slot
  assign w_id_is_cti        = (w_npc_sel != NPC_SEQ) && r_if_id.valid;

  npc_calc u_npc_calc (
    .i_pc      (r_pc),
    .i_npc_sel (w_npc_sel),
    .i_cmp     (id_cmp),
    .i_id_pc   (id_pc),
    .i_imm16   (id_imm16),
    .i_imm26   (id_imm26),
    .i_rs_data (id_rs_data),
    .o_npc_c   (w_npc)
  );

  // PC and IF/ID register: redirect > stall > normal fetch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= RESET_PC;
      r_if_id <= '0;
    end else if (redirect_valid) begin
      r_pc             <= redirect_pc;
      r_if_id.instr    <= NOP_WORD;
      r_if_id.pc       <= redirect_pc;
      r_if_id.valid    <= 1'b0;
      r_if_id.bd       <= 1'b0;
      r_if_id.exc_adel <= 1'b0;
    end else if (!stall) begin
      r_pc             <= w_npc;
      r_if_id.pc       <= r_pc;
      r_if_id.valid    <= 1'b1;
      r_if_id.bd       <= w_id_is_cti;
      r_if_id.exc_adel <= w_fetch_misaligned;
      r_if_id.instr    <= w_fetch_misaligned ? NOP_WORD : imem_rdata;
    end
  end

  assign imem_addr      = r_pc;
  assign if_id_instr    = r_if_id.instr;
  assign if_id_pc       = r_if_id.pc;
  assign if_id_valid    = r_if_id.valid;
  assign if_id_bd       = r_if_id.bd;
  assign if_id_exc_adel = r_if_id.exc_adel;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- IF stage of the 5-stage MIPS pipeline: owns the PC register, selects next PC, and drives the IF/ID pipeline register.
- Sits directly upstream of the ID-stage comparator. It consumes the comparator's `cmp` result and the ID-stage next-PC class, and resolves branches and jumps in ID.
- Architectural single delay slot: the instruction after a branch/jump is always fetched and passed on. No flush on taken branch.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, documentation only; the actual redirect target always comes from `redirect_pc`.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  fetch address; combinational copy of the PC register.
- imem_rdata  in  32  instruction word, combinational read of `imem_addr`.
- stall  in  1  hazard-unit stall; freezes PC and IF/ID.
- redirect_valid  in  1  exception/ERET redirect request from CP0.
- redirect_pc  in  32  redirect target.
- id_npc_sel  in  2  class of the instruction in ID: 0 = SEQ, 1 = BRANCH, 2 = JIMM, 3 = JREG.
- id_cmp  in  1  comparator result for the ID instruction.
- id_pc  in  32  PC of the ID instruction (IF/ID output fed back).
- id_imm16  in  16  branch offset field of the ID instruction.
- id_imm26  in  26  jump index field of the ID instruction.
- id_rs_data  in  32  forwarded rs value (JR/JALR target).
- if_id_instr  out  32  registered instruction to ID.
- if_id_pc  out  32  registered PC to ID.
- if_id_valid  out  1  0 = bubble.
- if_id_bd  out  1  registered instruction sits in a delay slot.
- if_id_exc_adel  out  1  registered instruction has a misaligned fetch address (AdEL).

Behaviour:
- Async reset (reset_n = 0), effective immediately:
  - PC = RESET_PC.
  - if_id_instr = 0 (NOP), if_id_pc = 0.
  - if_id_valid = 0, if_id_bd = 0, if_id_exc_adel = 0.
- `imem_addr` = PC at all times, including during reset.
- Next-PC candidate `npc`:
  - SEQ: PC + 4.
  - BRANCH: if id_cmp, id_pc + 4 + (sign_extend(id_imm16) << 2); else PC + 4.
  - JIMM: {id_pc_plus4[31:28], id_imm26, 2'b00}, where id_pc_plus4 = id_pc + 4.
  - JREG: id_rs_data, unmodified, even if misaligned.
- All arithmetic is 32-bit modulo 2^32; wrap-around is silent.
- Update priority on each rising edge:
  1. redirect_valid (overrides stall):
     - PC <= redirect_pc.
     - IF/ID loads a bubble: instr 0, valid 0, bd 0, exc 0, pc = redirect_pc.
  2. stall:
     - PC and all IF/ID outputs hold.
     - id_npc_sel and id_cmp are ignored; the ID instruction is re-evaluated when the stall releases.
  3. Normal:
     - PC <= npc.
     - if_id_pc <= PC, if_id_valid <= 1.
     - if_id_bd <= (id_npc_sel != SEQ) && if_id_valid.
     - If PC[1:0] != 0: if_id_exc_adel <= 1 and if_id_instr <= 0.
     - Otherwise: if_id_exc_adel <= 0 and if_id_instr <= imem_rdata.
- Delay slot: when a branch/jump is in ID, the instruction fetched that same cycle is captured normally with bd = 1, and PC moves to the target.
- A bubble in ID (if_id_valid = 0) never produces bd = 1, whatever id_npc_sel is.
- Back-to-back branches (branch in a delay slot): no special handling; the later ID instruction's npc wins in its own cycle.
- Reset asserted mid-stall or mid-redirect: reset wins asynchronously; the first fetch after release is at RESET_PC.
- Latency: one cycle from PC to IF/ID. Branch resolution adds zero penalty beyond the delay slot.

Decomposition:
- Shared package/header gets:
  - NPC_SEQ/NPC_BRANCH/NPC_JIMM/NPC_JREG encodings.
  - RESET_PC and EXC_VECTOR defaults.
  - NOP word 32'h0.
  - The 2-bit npc_sel width, shared with the ID decoder.
- One combinational sub-module, `npc_calc`, holds the npc mux and adders. The top keeps the PC register and the IF/ID register.

Test Plan:
- Reset: hold reset_n = 0, then release; imem_rdata = 32'h2408_0001.
  - During reset: imem_addr = 0x3000 and if_id_valid = 0.
  - After the first edge: if_id_instr = 32'h2408_0001, if_id_pc = 0x3000, PC = 0x3004.
- Taken branch: id_pc = 0x3008, id_npc_sel = BRANCH, id_cmp = 1, id_imm16 = 16'hFFFE.
  - Next PC = 0x3004; the delay slot at 0x300C is captured with bd = 1.
- Not-taken branch: same stimulus with id_cmp = 0.
  - Next PC = PC + 4; delay slot bd = 1.
- JREG misaligned: id_npc_sel = JREG, id_rs_data = 0x3012.
  - PC = 0x3012.
  - Next cycle: if_id_exc_adel = 1, if_id_instr = 0, if_id_pc = 0x3012.
- Stall vs redirect: assert stall for 3 cycles → PC and IF/ID unchanged each cycle.
  - Then stall = 1 together with redirect_valid = 1, redirect_pc = 0x4180 → PC = 0x4180 and if_id_valid = 0.
- JIMM wrap: id_pc = 0xFFFF_FFFC, id_imm26 = 26'h0000100.
  - Target = {4'h0, 26'h100, 2'b00} = 0x0000_0400.
